// File: rtl/instr_prefetch_queue.sv
// rtl/instr_prefetch_queue.sv - DEPTH-entry instruction prefetch FIFO with registered field-decoded output
module instr_prefetch_queue #(
  parameter int DEPTH    = 4,
  parameter int SIGN_EXT = 1,
  parameter int PC_W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [31:0]              in_instr,
  input  logic [PC_W-1:0]          in_pc,
  output logic                     in_ready,
  input  logic                     ir_write,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [5:0]               op,
  output logic [4:0]               rs,
  output logic [4:0]               rt,
  output logic [4:0]               rd,
  output logic [4:0]               shamt,
  output logic [5:0]               funct,
  output logic [15:0]              imm,
  output logic [31:0]              imm_ext,
  output logic [25:0]              j_imm,
  output logic [PC_W-1:0]          pc_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Queue storage; contents are don't-care until written, so no reset here.
  logic [31:0]     r_mem_instr [DEPTH];
  logic [PC_W-1:0] r_mem_pc    [DEPTH];

  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;

  // Instruction register: the decoded fields are slices of r_instr.
  logic [31:0]     r_instr;
  logic [31:0]     r_imm_ext;
  logic [PC_W-1:0] r_pc;
  logic            r_out_valid;

  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [31:0]     w_head_instr;
  logic [PC_W-1:0] w_head_pc;
  logic [31:0]     w_head_ext;

  // Status flags come only from the registered count, never from the handshakes.
  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  // Push is refused when full even if a pop happens in the same cycle.
  assign w_push  = in_valid && !w_full;
  // No bypass: a pop only sees words already held in the queue.
  assign w_pop   = ir_write && !w_empty;

  assign w_head_instr = r_mem_instr[r_rd_ptr];
  assign w_head_pc    = r_mem_pc[r_rd_ptr];

  // Immediate extension is computed from the head entry so it can be registered with the fields.
  always_comb begin
    w_head_ext = {16'b0, w_head_instr[15:0]};
    if (SIGN_EXT != 0) begin
      w_head_ext = {{16{w_head_instr[15]}}, w_head_instr[15:0]};
    end
  end

  // Write accepted fetch words into the circular buffer.
  always_ff @(posedge clk) begin
    if (!rst && !flush && w_push) begin
      r_mem_instr[r_wr_ptr] <= in_instr;
      r_mem_pc[r_wr_ptr]    <= in_pc;
    end
  end

  // Pointer and occupancy tracking; flush empties the queue like reset does.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Load the instruction register on a pop; an empty pop or flush leaves a bubble but keeps the fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr     <= '0;
      r_imm_ext   <= '0;
      r_pc        <= '0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (ir_write) begin
      if (w_pop) begin
        r_instr     <= w_head_instr;
        r_imm_ext   <= w_head_ext;
        r_pc        <= w_head_pc;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = !w_full;
  assign empty     = w_empty;
  assign full      = w_full;
  assign count     = r_count;
  assign out_valid = r_out_valid;
  assign op        = r_instr[31:26];
  assign rs        = r_instr[25:21];
  assign rt        = r_instr[20:16];
  assign rd        = r_instr[15:11];
  assign shamt     = r_instr[10:6];
  assign funct     = r_instr[5:0];
  assign imm       = r_instr[15:0];
  assign j_imm     = r_instr[25:0];
  assign imm_ext   = r_imm_ext;
  assign pc_out    = r_pc;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb/tb_instr_prefetch_queue.sv - randomized scoreboard bench for instr_prefetch_queue
module tb_instr_prefetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        ir_write;
  logic        flush;

  logic        in_ready, out_valid, empty, full;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] imm_ext;
  logic [25:0] j_imm;
  logic [31:0] pc_out;
  logic [2:0]  count;

  logic        z_in_ready, z_out_valid, z_empty, z_full;
  logic [5:0]  z_op, z_funct;
  logic [4:0]  z_rs, z_rt, z_rd, z_shamt;
  logic [15:0] z_imm;
  logic [31:0] z_imm_ext;
  logic [25:0] z_j_imm;
  logic [31:0] z_pc_out;
  logic [2:0]  z_count;

  instr_prefetch_queue #(.DEPTH(DEPTH), .SIGN_EXT(1), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
    .in_ready(in_ready), .ir_write(ir_write), .flush(flush), .out_valid(out_valid),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm(imm),
    .imm_ext(imm_ext), .j_imm(j_imm), .pc_out(pc_out), .count(count),
    .empty(empty), .full(full)
  );

  instr_prefetch_queue #(.DEPTH(DEPTH), .SIGN_EXT(0), .PC_W(32)) dut_z (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
    .in_ready(z_in_ready), .ir_write(ir_write), .flush(flush), .out_valid(z_out_valid),
    .op(z_op), .rs(z_rs), .rt(z_rt), .rd(z_rd), .shamt(z_shamt), .funct(z_funct), .imm(z_imm),
    .imm_ext(z_imm_ext), .j_imm(z_j_imm), .pc_out(z_pc_out), .count(z_count),
    .empty(z_empty), .full(z_full)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a plain queue of {pc, instr} plus the visible output register.
  logic [63:0] m_q[$];
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic        m_valid;

  function automatic logic [31:0] ext_s(input logic [31:0] w);
    int unsigned v;
    v = w & 32'hFFFF;
    if (v >= 32768) v = v + 32'hFFFF0000;
    return v;
  endfunction

  task automatic model_step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                            input logic irw, input logic fl, input logic r);
    int sz;
    logic [63:0] e;
    sz = m_q.size();
    if (r) begin
      m_q.delete();
      m_instr = 0; m_pc = 0; m_valid = 0;
    end else if (fl) begin
      m_q.delete();
      m_valid = 0;
    end else begin
      if (irw) begin
        if (sz > 0) begin
          e = m_q.pop_front();
          m_instr = e[31:0];
          m_pc    = e[63:32];
          m_valid = 1;
        end else begin
          m_valid = 0;
        end
      end
      if (v && sz < DEPTH) m_q.push_back({pc, ins});
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".count"},    count,     m_q.size());
    chk({tag, ".empty"},    empty,     m_q.size() == 0);
    chk({tag, ".full"},     full,      m_q.size() == DEPTH);
    chk({tag, ".in_ready"}, in_ready,  m_q.size() != DEPTH);
    chk({tag, ".valid"},    out_valid, m_valid);
    chk({tag, ".op"},       op,        m_instr >> 26);
    chk({tag, ".rs"},       rs,        (m_instr >> 21) & 31);
    chk({tag, ".rt"},       rt,        (m_instr >> 16) & 31);
    chk({tag, ".rd"},       rd,        (m_instr >> 11) & 31);
    chk({tag, ".shamt"},    shamt,     (m_instr >> 6) & 31);
    chk({tag, ".funct"},    funct,     m_instr & 63);
    chk({tag, ".imm"},      imm,       m_instr & 32'hFFFF);
    chk({tag, ".j_imm"},    j_imm,     m_instr & 32'h03FF_FFFF);
    chk({tag, ".imm_ext"},  imm_ext,   ext_s(m_instr));
    chk({tag, ".pc_out"},   pc_out,    m_pc);
    chk({tag, ".z_imm_ext"}, z_imm_ext, m_instr & 32'hFFFF);
    chk({tag, ".z_pc_out"},  z_pc_out,  m_pc);
    chk({tag, ".z_count"},   z_count,   m_q.size());
    chk({tag, ".z_valid"},   z_out_valid, m_valid);
  endtask

  task automatic step(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic irw, input logic fl, input logic r);
    in_valid = v; in_instr = ins; in_pc = pc; ir_write = irw; flush = fl; rst = r;
    @(posedge clk);
    #1;
    model_step(v, ins, pc, irw, fl, r);
    compare_all(tag);
  endtask

  logic [31:0] pc_ctr;
  logic [31:0] saved_pc;

  initial begin
    m_instr = 0; m_pc = 0; m_valid = 0;
    in_valid = 0; in_instr = 0; in_pc = 0; ir_write = 0; flush = 0; rst = 1;

    step("rst0", 0, 0, 0, 0, 0, 1);
    step("rst1", 0, 0, 0, 0, 0, 1);
    chk("rst.empty", empty, 1);
    chk("rst.in_ready", in_ready, 1);

    step("lw_push", 1, 32'h8C22_0004, 32'h100, 0, 0, 0);
    step("lw_pop",  0, 0, 0, 1, 0, 0);
    chk("lw.op", op, 6'h23);
    chk("lw.rs", rs, 1);
    chk("lw.rt", rt, 2);
    chk("lw.imm", imm, 16'h0004);
    chk("lw.imm_ext", imm_ext, 32'h4);
    chk("lw.pc", pc_out, 32'h100);
    chk("lw.valid", out_valid, 1);

    step("neg_push", 1, 32'h2021_FFFF, 32'h104, 0, 0, 0);
    step("neg_pop",  0, 0, 0, 1, 0, 0);
    chk("neg.sext", imm_ext, 32'hFFFF_FFFF);
    chk("neg.zext", z_imm_ext, 32'h0000_FFFF);

    step("add_push", 1, 32'h0043_2020, 32'h108, 0, 0, 0);
    step("add_pop",  0, 0, 0, 1, 0, 0);
    chk("add.rd", rd, 4);
    chk("add.shamt", shamt, 0);
    chk("add.funct", funct, 6'h20);

    for (int i = 0; i < 5; i++) begin
      step("fill", 1, $urandom, 32'h200 + i * 4, 0, 0, 0);
      if (i == 3) begin
        chk("fill.full", full, 1);
        chk("fill.in_ready", in_ready, 0);
      end
    end
    chk("fill.count", count, 4);
    for (int i = 0; i < 4; i++) begin
      step("drain", 0, 0, 0, 1, 0, 0);
      chk("drain.pc", pc_out, 32'h200 + i * 4);
    end
    chk("drain.empty", empty, 1);

    step("wrap_prime", 1, $urandom, 32'h300, 0, 0, 0);
    for (int i = 1; i <= 3 * DEPTH; i++) begin
      step("wrap", 1, $urandom, 32'h300 + i * 4, 1, 0, 0);
      chk("wrap.pc", pc_out, 32'h300 + (i - 1) * 4);
      chk("wrap.count", count, 1);
    end
    step("wrap_last", 0, 0, 0, 1, 0, 0);
    chk("wrap.last_pc", pc_out, 32'h300 + 3 * DEPTH * 4);

    for (int i = 0; i < 4; i++) step("fl_fill", 1, $urandom, 32'h400 + i * 4, 0, 0, 0);
    step("fl_pop", 0, 0, 0, 1, 0, 0);
    chk("fl.pre_count", count, 3);
    saved_pc = pc_out;
    step("flush", 1, 32'hDEAD_BEEF, 32'hBAD0, 1, 1, 0);
    chk("flush.count", count, 0);
    chk("flush.valid", out_valid, 0);
    chk("flush.pc_hold", pc_out, saved_pc);
    step("fl_after", 0, 0, 0, 1, 0, 0);
    chk("fl_after.pc_hold", pc_out, saved_pc);

    step("ep_push", 1, 32'h1234_5678, 32'h500, 1, 0, 0);
    chk("ep.count", count, 1);
    chk("ep.valid", out_valid, 0);
    step("ep_pop", 0, 0, 0, 1, 0, 0);
    chk("ep.pc", pc_out, 32'h500);
    step("ep_bubble", 0, 0, 0, 1, 0, 0);
    chk("ep_bubble.valid", out_valid, 0);
    chk("ep_bubble.pc_hold", pc_out, 32'h500);

    step("r_fill0", 1, $urandom, 32'h600, 0, 0, 0);
    step("r_fill1", 1, $urandom, 32'h604, 0, 0, 0);
    step("mid_rst", 1, $urandom, 32'h608, 1, 0, 1);
    chk("mid_rst.pc", pc_out, 0);
    chk("mid_rst.empty", empty, 1);
    chk("mid_rst.in_ready", in_ready, 1);

    pc_ctr = 32'h1000;
    for (int i = 0; i < 600; i++) begin
      logic v, irw, fl, r;
      v   = ($urandom_range(0, 99) < 65);
      irw = ($urandom_range(0, 99) < 55);
      fl  = ($urandom_range(0, 99) < 3);
      r   = ($urandom_range(0, 199) == 0);
      step("rand", v, $urandom, pc_ctr, irw, fl, r);
      pc_ctr = pc_ctr + 4;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
